// File: rtl/apb_mem_pkg.sv
// rtl/apb_mem_pkg.sv - shared types, constants and helpers for the APB memory slave
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_DATAWIDTH = 32;
  localparam int STRB_W        = DEF_DATAWIDTH / 8;
  localparam int IDX_LSB       = clog2(STRB_W);

  localparam int PPROT_PRIV_BIT  = 0;
  localparam int PPROT_NSEC_BIT  = 1;
  localparam int PPROT_INSTR_BIT = 2;

endpackage

// File: rtl/apb_mem_slave_ws_if.sv
// rtl/apb_mem_slave_ws_if.sv - APB4 bus bundle with master/slave modports
interface apb_mem_slave_ws_if #(
  parameter int ADDWIDTH  = 12,
  parameter int DATAWIDTH = 32
) ();
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDWIDTH-1:0]    PADDR;
  logic [DATAWIDTH/8-1:0] PSTRB;
  logic [DATAWIDTH-1:0]   PWDATA;
  logic [2:0]             PPROT;
  logic                   PREADY;
  logic [DATAWIDTH-1:0]   PRDATA;
  logic                   PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, PPROT,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave_ws_bank.sv
// rtl/apb_mem_slave_ws_bank.sv - word storage with byte-lane writes and a registered read port
module apb_mem_bank #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 256,
  parameter int AW        = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  input  logic [AW-1:0]          idx_i,
  input  logic [DATAWIDTH/8-1:0] strb_i,
  input  logic [DATAWIDTH-1:0]   wdata_i,
  output logic [DATAWIDTH-1:0]   rdata_o
);
  logic [DATAWIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the caller gates wr_en_i during reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < DATAWIDTH / 8; i++) begin
        if (strb_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read data is held only for the cycle after rd_en_i, otherwise zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (rd_en_i) begin
      rdata_o <= mem_q[idx_i];
    end else begin
      rdata_o <= '0;
    end
  end
endmodule

// File: rtl/apb_mem_slave_ws.sv
// rtl/apb_mem_slave_ws.sv - APB4 memory slave with wait states and PSLVERR; optional APB_PROT_CHECK_EN
module apb_mem_slave_ws
  import apb_mem_pkg::*;
#(
  parameter int ADDWIDTH    = 12,
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic                PCLK,
  input logic                PRESET,
  apb_mem_slave_ws_if.slave  apb
);
  localparam int          NSTRB     = DATAWIDTH / 8;
  localparam int          ALSB      = clog2(NSTRB);
  localparam int          IDXW      = ADDWIDTH - ALSB;
  localparam int          BANK_AW   = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U   = DEPTH;
  localparam logic [31:0] HALF_U    = DEPTH_U >> 1;
  localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  state_e               state_q;
  logic [7:0]           cnt_q;
  logic [IDXW-1:0]      idx_q;
  logic                 write_q;
  logic [NSTRB-1:0]     strb_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic                 err_q;
  logic                 pready_q;
  logic                 pslverr_q;

  logic                 setup;
  logic [IDXW-1:0]      bus_idx;
  logic                 prot_fail;
  logic                 bus_err;
  logic [IDXW-1:0]      acc_idx;
  logic                 acc_write;
  logic [NSTRB-1:0]     acc_strb;
  logic [DATAWIDTH-1:0] acc_wdata;
  logic                 acc_err;
  logic                 go_resp;
  logic                 bank_wr;
  logic                 bank_rd;
  logic [DATAWIDTH-1:0] bank_rdata;

  assign setup   = apb.PSEL && !apb.PENABLE;
  assign bus_idx = apb.PADDR[ADDWIDTH-1:ALSB];

`ifdef APB_PROT_CHECK_EN
  assign prot_fail = (32'(bus_idx) >= HALF_U) && !apb.PPROT[PPROT_PRIV_BIT];
`else
  assign prot_fail = 1'b0;
`endif

  assign bus_err = (32'(bus_idx) >= DEPTH_U) || (!apb.PWRITE && (apb.PSTRB != '0)) || prot_fail;

  // With no wait states the commit happens on the setup edge, so the
  // access attributes come straight from the bus instead of the latches.
  always_comb begin
    acc_idx   = idx_q;
    acc_write = write_q;
    acc_strb  = strb_q;
    acc_wdata = wdata_q;
    acc_err   = err_q;
    go_resp   = 1'b0;
    if (state_q == IDLE) begin
      acc_idx   = bus_idx;
      acc_write = apb.PWRITE;
      acc_strb  = apb.PSTRB;
      acc_wdata = apb.PWDATA;
      acc_err   = bus_err;
      go_resp   = setup && NO_WAIT;
    end else if (state_q == WAIT) begin
      go_resp   = apb.PSEL && (cnt_q == 8'd1);
    end
  end

  assign bank_wr = go_resp && !PRESET && acc_write && !acc_err;
  assign bank_rd = go_resp && !PRESET && !acc_write && !acc_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= go_resp;
      pslverr_q <= go_resp && acc_err;
      case (state_q)
        IDLE: begin
          if (setup) begin
            idx_q   <= acc_idx;
            write_q <= acc_write;
            strb_q  <= acc_strb;
            wdata_q <= acc_wdata;
            err_q   <= acc_err;
            cnt_q   <= WAIT_LOAD;
            state_q <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!apb.PSEL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 8'd1) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_mem_bank #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH),
    .AW        (BANK_AW)
  ) u_bank (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .wr_en_i (bank_wr),
    .rd_en_i (bank_rd),
    .idx_i   (acc_idx[BANK_AW-1:0]),
    .strb_i  (acc_strb),
    .wdata_i (acc_wdata),
    .rdata_o (bank_rdata)
  );

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = bank_rdata;

  wire _unused_ok = &{1'b0, apb.PPROT, apb.PADDR, acc_idx, 1'b0};
endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// tb/tb_apb_mem_slave_ws.sv - directed bench over three wait-state configurations
module tb_apb_mem_slave_ws;
  import apb_mem_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  int          tgt;

  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] rd;
  logic        er, zok;
  int          lo;

  apb_mem_slave_ws_if #(.ADDWIDTH(12), .DATAWIDTH(32)) if0 ();
  apb_mem_slave_ws_if #(.ADDWIDTH(12), .DATAWIDTH(32)) if1 ();
  apb_mem_slave_ws_if #(.ADDWIDTH(12), .DATAWIDTH(32)) if2 ();

  assign if0.PSEL = psel && (tgt == 0);
  assign if1.PSEL = psel && (tgt == 1);
  assign if2.PSEL = psel && (tgt == 2);
  assign if0.PENABLE = penable;  assign if1.PENABLE = penable;  assign if2.PENABLE = penable;
  assign if0.PWRITE  = pwrite;   assign if1.PWRITE  = pwrite;   assign if2.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;    assign if1.PADDR   = paddr;    assign if2.PADDR   = paddr;
  assign if0.PSTRB   = pstrb;    assign if1.PSTRB   = pstrb;    assign if2.PSTRB   = pstrb;
  assign if0.PWDATA  = pwdata;   assign if1.PWDATA  = pwdata;   assign if2.PWDATA  = pwdata;
  assign if0.PPROT   = pprot;    assign if1.PPROT   = pprot;    assign if2.PPROT   = pprot;

  apb_mem_slave_ws #(.ADDWIDTH(12), .DATAWIDTH(32), .DEPTH(256), .WAIT_CYCLES(0))
    dut0 (.PCLK(clk), .PRESET(preset), .apb(if0));
  apb_mem_slave_ws #(.ADDWIDTH(12), .DATAWIDTH(32), .DEPTH(256), .WAIT_CYCLES(3))
    dut1 (.PCLK(clk), .PRESET(preset), .apb(if1));
  apb_mem_slave_ws #(.ADDWIDTH(12), .DATAWIDTH(32), .DEPTH(256), .WAIT_CYCLES(4))
    dut2 (.PCLK(clk), .PRESET(preset), .apb(if2));

  always_comb begin
    s_pready  = if0.PREADY;
    s_pslverr = if0.PSLVERR;
    s_prdata  = if0.PRDATA;
    case (tgt)
      1: begin s_pready = if1.PREADY; s_pslverr = if1.PSLVERR; s_prdata = if1.PRDATA; end
      2: begin s_pready = if2.PREADY; s_pslverr = if2.PSLVERR; s_prdata = if2.PRDATA; end
      default: ;
    endcase
  end

  // Drives one transfer and leaves PSEL high so a following call is back-to-back.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, input logic [2:0] prot,
                      output logic [31:0] rdata, output logic err, output int lows,
                      output logic zero_ok);
    logic timeout;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pstrb = strb; pwdata = wdata; pprot = prot;
    lows = 0; zero_ok = 1'b1; rdata = '0; err = 1'b0; timeout = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (s_pready) begin
        rdata = s_prdata; err = s_pslverr; timeout = 1'b0;
        break;
      end
      lows++;
      if (s_prdata !== 32'h0) zero_ok = 1'b0;
      @(negedge clk);
    end
    assertions++;
    if (timeout) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h got no PREADY within 64 cycles, required PREADY", addr);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
  endtask

  task automatic test_reset();
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pstrb = '0; pwdata = '0; pprot = 3'b001; tgt = 0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      tgt = t;
      #1;
      assertions++;
      if (s_pready !== 1'b0) begin failures++; $display("FAIL reset_pready dut%0d got %b required 0", t, s_pready); end
      assertions++;
      if (s_pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr dut%0d got %b required 0", t, s_pslverr); end
      assertions++;
      if (s_prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata dut%0d got %h required 0", t, s_prdata); end
    end
    tgt = 0;
    @(negedge clk);
    preset = 1'b0;
  endtask

  task automatic test_basic_w0();
    tgt = 0;
    xfer(1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 3'b001, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b0) begin failures++; $display("FAIL w0_write_err got %b required 0", er); end
    assertions++;
    if (lo != 0) begin failures++; $display("FAIL w0_write_lows got %0d required 0", lo); end
    xfer(1'b0, 12'h010, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL w0_read_data got %h required deadbeef", rd); end
    assertions++;
    if (er !== 1'b0) begin failures++; $display("FAIL w0_read_err got %b required 0", er); end
    assertions++;
    if (lo != 0) begin failures++; $display("FAIL w0_read_lows got %0d required 0", lo); end
    idle();
    assertions++;
    if (s_pready !== 1'b0 || s_prdata !== 32'h0) begin
      failures++; $display("FAIL w0_after_resp got pready=%b prdata=%h required 0/0", s_pready, s_prdata);
    end
    xfer(1'b0, 12'h013, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL w0_low_addr_bits got %h err=%b required deadbeef err=0", rd, er);
    end
    idle();
  endtask

  task automatic test_wait_states();
    tgt = 1;
    xfer(1'b1, 12'h020, 4'hF, 32'h12345678, 3'b001, rd, er, lo, zok);
    assertions++;
    if (lo != 3) begin failures++; $display("FAIL w3_write_lows got %0d required 3", lo); end
    xfer(1'b0, 12'h020, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (lo != 3) begin failures++; $display("FAIL w3_read_lows got %0d required 3", lo); end
    assertions++;
    if (zok !== 1'b1) begin failures++; $display("FAIL w3_prdata_while_low got nonzero required 0"); end
    assertions++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      failures++; $display("FAIL w3_read_data got %h err=%b required 12345678 err=0", rd, er);
    end
    @(negedge clk);
    assertions++;
    if (s_pready !== 1'b0) begin failures++; $display("FAIL w3_ready_one_cycle got %b required 0", s_pready); end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_strobe();
    tgt = 0;
    xfer(1'b1, 12'h040, 4'hF, 32'h11223344, 3'b001, rd, er, lo, zok);
    xfer(1'b1, 12'h040, 4'b0101, 32'hAABBCCDD, 3'b001, rd, er, lo, zok);
    xfer(1'b0, 12'h040, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_merge got %h required 11bb33dd", rd); end
    xfer(1'b0, 12'h040, 4'h1, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL strobe_read_err got err=%b data=%h required err=1 data=0", er, rd);
    end
    xfer(1'b1, 12'h040, 4'h0, 32'hFFFFFFFF, 3'b001, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b0) begin failures++; $display("FAIL strobe_zero_err got %b required 0", er); end
    xfer(1'b0, 12'h040, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_zero_nowrite got %h required 11bb33dd", rd); end
    idle();
  endtask

  task automatic test_out_of_range();
    tgt = 0;
    xfer(1'b1, 12'h000, 4'hF, 32'hCAFEF00D, 3'b001, rd, er, lo, zok);
    xfer(1'b1, 12'h400, 4'hF, 32'h55555555, 3'b001, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b1) begin failures++; $display("FAIL oor_write_err got %b required 1", er); end
    xfer(1'b0, 12'h000, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL oor_no_alias got %h required cafef00d", rd); end
    xfer(1'b1, 12'h3FC, 4'hF, 32'h0BADC0DE, 3'b001, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b0) begin failures++; $display("FAIL top_word_err got %b required 0", er); end
    xfer(1'b0, 12'h3FC, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL top_word_data got %h required 0badc0de", rd); end
    xfer(1'b0, 12'h7F0, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL oor_read got err=%b data=%h required err=1 data=0", er, rd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    tgt = 1;
    xfer(1'b1, 12'h080, 4'hF, 32'hA5A5A5A5, 3'b001, rd, er, lo, zok);
    xfer(1'b1, 12'h084, 4'hF, 32'h5A5A5A5A, 3'b001, rd, er, lo, zok);
    xfer(1'b0, 12'h080, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'hA5A5A5A5 || lo != 3) begin
      failures++; $display("FAIL b2b_first got %h lows=%0d required a5a5a5a5 lows=3", rd, lo);
    end
    xfer(1'b0, 12'h084, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h5A5A5A5A || lo != 3) begin
      failures++; $display("FAIL b2b_second got %h lows=%0d required 5a5a5a5a lows=3", rd, lo);
    end
    idle();
  endtask

  task automatic test_abort();
    int highs;
    tgt = 2;
    xfer(1'b1, 12'h050, 4'hF, 32'h600DCAFE, 3'b001, rd, er, lo, zok);
    assertions++;
    if (lo != 4) begin failures++; $display("FAIL w4_lows got %0d required 4", lo); end
    idle();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h050; pstrb = 4'hF; pwdata = 32'hBAD0BAD0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_pready) highs++;
    end
    assertions++;
    if (highs != 0) begin failures++; $display("FAIL abort_pready got %0d high cycles required 0", highs); end
    xfer(1'b0, 12'h050, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h600DCAFE) begin failures++; $display("FAIL abort_nowrite got %h required 600dcafe", rd); end
    idle();
  endtask

  task automatic test_reset_mid();
    tgt = 2;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h050; pstrb = 4'hF; pwdata = 32'h12121212;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); preset = 1'b1;
    @(negedge clk);
    assertions++;
    if (s_pready !== 1'b0 || s_pslverr !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs got pready=%b pslverr=%b required 0/0", s_pready, s_pslverr);
    end
    assertions++;
    if (dut2.state_q !== IDLE) begin failures++; $display("FAIL rst_mid_state got %0d required IDLE", dut2.state_q); end
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 12'h050, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h600DCAFE || er !== 1'b0 || lo != 4) begin
      failures++; $display("FAIL rst_mid_recover got %h err=%b lows=%0d required 600dcafe err=0 lows=4", rd, er, lo);
    end
    idle();
  endtask

`ifdef APB_PROT_CHECK_EN
  task automatic test_prot();
    tgt = 0;
    xfer(1'b1, 12'h320, 4'hF, 32'h01010101, 3'b001, rd, er, lo, zok);
    xfer(1'b1, 12'h320, 4'hF, 32'hFFFFFFFF, 3'b000, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b1) begin failures++; $display("FAIL prot_write_err got %b required 1", er); end
    xfer(1'b0, 12'h320, 4'h0, 32'h0, 3'b000, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL prot_read_err got err=%b data=%h required err=1 data=0", er, rd);
    end
    xfer(1'b0, 12'h320, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h01010101) begin failures++; $display("FAIL prot_unchanged got %h required 01010101", rd); end
    xfer(1'b1, 12'h320, 4'hF, 32'h2468ACE0, 3'b001, rd, er, lo, zok);
    xfer(1'b0, 12'h320, 4'h0, 32'h0, 3'b001, rd, er, lo, zok);
    assertions++;
    if (rd !== 32'h2468ACE0 || er !== 1'b0) begin
      failures++; $display("FAIL prot_priv_write got %h err=%b required 2468ace0 err=0", rd, er);
    end
    xfer(1'b0, 12'h010, 4'h0, 32'h0, 3'b000, rd, er, lo, zok);
    assertions++;
    if (er !== 1'b0) begin failures++; $display("FAIL prot_lower_half got err=%b required 0", er); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_w0();
    test_wait_states();
    test_strobe();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef APB_PROT_CHECK_EN
    test_prot();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/apb_mem_slave_ws.md
Name: apb_mem_slave_ws

Overview:
- Parametrised successor to the basic APB4 memory slave.
- Memory of DEPTH words with byte addressing, byte strobes, a programmable number of wait states (PREADY stretching) and PSLVERR reporting.
- Sits on the APB side of the bridge as a generic scratch/config RAM target; one instance per PSELx.

Parameters:
- ADDWIDTH, 12, PADDR width in bits (byte address).
- DATAWIDTH, 32, data width; legal values 8/16/32/64.
- DEPTH, 256, number of DATAWIDTH words; must be ≤ 2**(ADDWIDTH-log2(DATAWIDTH/8)).
- WAIT_CYCLES, 0, access-phase cycles with PREADY low before completion; 0..255.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDWIDTH  byte address.
- PSTRB  in  DATAWIDTH/8  write byte lanes.
- PWDATA  in  DATAWIDTH  write data.
- PPROT  in  3  protection attributes; used only with APB_PROT_CHECK_EN.
- PREADY  out  1  transfer completion, registered.
- PRDATA  out  DATAWIDTH  read data, registered; 0 when PREADY is low.
- PSLVERR  out  1  error response, registered; valid only with PREADY.

Interface decision: one clock PCLK; reset PRESET is synchronous and active-high.

Behaviour:
- Word index: IDX = PADDR[ADDWIDTH-1:log2(DATAWIDTH/8)]. Low address bits are ignored and are not an error.
- FSM states: IDLE, WAIT, RESP.
- IDLE, setup detect (PSEL & !PENABLE):
  - Latch IDX, PWRITE, PSTRB, PWDATA.
  - Compute err = (IDX >= DEPTH) | (!PWRITE & PSTRB != 0) [| prot fail, see Optional Feature].
  - Load cnt = WAIT_CYCLES.
  - Go to RESP if WAIT_CYCLES == 0, else WAIT.
- WAIT:
  - cnt decrements each cycle; PREADY = 0.
  - When cnt == 1, go to RESP.
  - The access phase therefore shows exactly WAIT_CYCLES cycles with PREADY low.
- Entering RESP (registered outputs):
  - PREADY <= 1; PSLVERR <= err.
  - PRDATA <= mem[IDX] for a read without error, else 0.
  - Write commit happens on the RESP-entry edge when PWRITE & !err: for each lane i with PSTRB[i] set, mem[IDX][8i+:8] <= PWDATA[8i+:8].
  - No memory change on error or when PSTRB == 0.
- Latency: with W = WAIT_CYCLES, the transfer completes in 2+W cycles (setup + W wait + 1 ready).
- RESP to IDLE unconditionally. PREADY, PRDATA and PSLVERR return to 0 the next cycle.
- Back-to-back: a new setup cycle directly after RESP is accepted (state is IDLE).
- Abort: PSEL deasserted in WAIT or RESP → go to IDLE, outputs cleared, and no write if still in WAIT.
- PENABLE high in IDLE without a preceding setup is ignored.
- Reset: any cycle with PRESET = 1 → IDLE, cnt = 0, PREADY/PSLVERR/PRDATA = 0. Memory is not cleared (contents undefined after power-up), and no write occurs in a reset cycle.
- Reset mid-transfer aborts the transfer; the pending write is dropped.

Optional Feature:
- Macro: APB_PROT_CHECK_EN.
- Defined: the upper half of memory (IDX >= DEPTH/2) requires PPROT[0] = 1 (privileged). A non-privileged access there sets err: PSLVERR on completion, write suppressed, PRDATA = 0.
- Undefined: PPROT is ignored (port kept, unused); only range and read-strobe errors apply.

Decomposition:
- Package apb_mem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - function clog2;
  - localparams STRB_W = DATAWIDTH/8 and IDX_LSB = clog2(STRB_W);
  - PPROT bit-position constants.
- Sub-module apb_mem_bank: storage array, byte-lane write with strobe, synchronous read port (read enable, index, data). The FSM/err logic stays in the top.

Test Plan:
- W=0, DATAWIDTH=32: write 0xDEADBEEF to PADDR 0x010, PSTRB=0xF, then read 0x010 → PREADY high in the first access cycle; PRDATA = 0xDEADBEEF; PSLVERR = 0.
- W=3: read → PREADY low for exactly 3 access cycles then high for 1; PRDATA = 0 while PREADY is low.
- Strobe: preload 0x11223344, write 0xAABBCCDD with PSTRB=0b0101 → readback 0x11BB33DD. A read with PSTRB=0x1 → PSLVERR = 1, PRDATA = 0.
- Out of range, DEPTH=256: write to PADDR 0x400 (IDX 256) → PSLVERR = 1. Subsequent read of IDX 0 is unchanged (no alias write).
- Abort/reset, W=4: drop PSEL after 2 wait cycles during a write → no memory change. Assert PRESET during WAIT → next cycle PREADY = 0, PSLVERR = 0, state IDLE; the next transfer completes normally.
- APB_PROT_CHECK_EN: write IDX 200 with PPROT=3'b000 → PSLVERR = 1, data unchanged. With PPROT=3'b001 → write succeeds; readback matches.
